pc_adder: RTL and testbench

Program-counter adder and PC register for the RV32 fetch stage. It provides a purely combinational sequential-address adder, `pc = PC_itself + 4`, used wherever the datapath needs PC+4, such as link-register writeback. It also holds the architectural PC register, whose next value is chosen from sequential, branch, JALR and trap sources. It sits between the instruction-memory address port and the branch/jump resolution logic.

---
 rtl/pc_pkg.sv | 7 +
 rtl/pc_next_mux.sv | 23 ++
 rtl/pc_adder.sv | 46 ++++
 tb/tb_pc_adder.sv | 109 ++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// pc_pkg: shared PC widths, reset vector, step and next-PC source encoding
package pc_pkg;
  localparam int XLEN = 32;
  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
  localparam int INCREMENT = 4;
  typedef enum logic [1:0] {NPC_SEQ, NPC_BRANCH, NPC_JALR, NPC_TRAP} npc_sel_t;
endpackage

// File: rtl/pc_next_mux.sv
// pc_next_mux: priority encoder for the next-PC source plus the four-way target mux
module pc_next_mux
  import pc_pkg::*;
#(
  parameter int W = pc_pkg::XLEN
) (
  input  logic         trap_en_i,
  input  logic         jalr_en_i,
  input  logic         branch_taken_i,
  input  logic [W-1:0] trap_tgt_i,
  input  logic [W-1:0] jalr_tgt_i,
  input  logic [W-1:0] branch_tgt_i,
  input  logic [W-1:0] seq_tgt_i,
  output logic [W-1:0] next_o
);
  npc_sel_t sel;
  always_comb begin
    sel = trap_en_i ? NPC_TRAP : jalr_en_i ? NPC_JALR : branch_taken_i ? NPC_BRANCH : NPC_SEQ;
    next_o = (sel == NPC_TRAP)   ? trap_tgt_i :
             (sel == NPC_JALR)   ? jalr_tgt_i :
             (sel == NPC_BRANCH) ? branch_tgt_i : seq_tgt_i;
  end
endmodule

// File: rtl/pc_adder.sv
// pc_adder: combinational PC+INCREMENT adder and the architectural PC register
module pc_adder
  import pc_pkg::*;
#(
  parameter int               XLEN         = pc_pkg::XLEN,
  parameter logic [XLEN-1:0]  RESET_VECTOR = pc_pkg::RESET_VECTOR,
  parameter int               INCREMENT    = pc_pkg::INCREMENT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] PC_itself,
  output logic [XLEN-1:0] pc,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_offset,
  input  logic            jalr_en,
  input  logic [XLEN-1:0] jalr_base,
  input  logic [XLEN-1:0] jalr_offset,
  input  logic            trap_en,
  input  logic [XLEN-1:0] trap_vector,
  output logic [XLEN-1:0] pc_q,
  output logic [XLEN-1:0] pc_next,
  output logic            misaligned
);
  logic [XLEN-1:0] jalr_sum, mux_out, pc_d;
  assign pc       = PC_itself + XLEN'(INCREMENT);
  assign jalr_sum = jalr_base + jalr_offset;
  pc_next_mux #(.W(XLEN)) u_mux (
    .trap_en_i      (trap_en),
    .jalr_en_i      (jalr_en),
    .branch_taken_i (branch_taken),
    .trap_tgt_i     (trap_vector),
    .jalr_tgt_i     ({jalr_sum[XLEN-1:1], 1'b0}),
    .branch_tgt_i   (pc_q + branch_offset),
    .seq_tgt_i      (pc_q + XLEN'(INCREMENT)),
    .next_o         (mux_out)
  );
  // a trap still redirects through a stall
  assign pc_d       = (stall && !trap_en) ? pc_q : mux_out;
  assign pc_next    = pc_d;
  assign misaligned = (pc_d[1:0] != 2'b00) && !trap_en;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= RESET_VECTOR;
    else        pc_q <= pc_d;
  end
endmodule

// File: tb/tb_pc_adder.sv
// tb_pc_adder: vector table, directed sequences and a randomized model check for pc_adder
module tb_pc_adder;
  logic        clk = 0, rst_n = 0;
  logic [31:0] PC_itself = 0, pc, branch_offset = 0, jalr_base = 0, jalr_offset = 0, trap_vector = 0;
  logic [31:0] pc_q, pc_next;
  logic        stall = 0, branch_taken = 0, jalr_en = 0, trap_en = 0, misaligned;
  int n_tests = 0, n_fail = 0;

  pc_adder dut (
    .clk(clk), .rst_n(rst_n), .PC_itself(PC_itself), .pc(pc), .stall(stall),
    .branch_taken(branch_taken), .branch_offset(branch_offset), .jalr_en(jalr_en),
    .jalr_base(jalr_base), .jalr_offset(jalr_offset), .trap_en(trap_en),
    .trap_vector(trap_vector), .pc_q(pc_q), .pc_next(pc_next), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] in; logic [31:0] exp; } vec_t;
  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_ctrl();
    stall = 0; branch_taken = 0; jalr_en = 0; trap_en = 0;
  endtask

  task automatic edge_then_settle();
    @(posedge clk); #1;
  endtask

  logic [31:0] m_pc, exp_next;
  initial begin
    vecs[0] = '{32'h0, 32'h4};
    vecs[1] = '{32'h1, 32'h5};
    vecs[2] = '{32'hFF, 32'h103};
    vecs[3] = '{32'hC3, 32'hC7};
    vecs[4] = '{32'hFFFFFED1, 32'hFFFFFED5};
    vecs[5] = '{32'hFFFFFFFC, 32'h0};
    vecs[6] = '{32'hFFFFFFFE, 32'h2};
    // combinational sweep, run while reset is held to show pc ignores it
    for (int i = 0; i < 7; i++) begin
      PC_itself = vecs[i].in;
      #10;
      chk($sformatf("pc_sweep[%0d]", i), pc, vecs[i].exp);
    end
    chk("reset_hold_pc_q", pc_q, 32'h0);
    @(negedge clk); rst_n = 1;
    edge_then_settle();
    edge_then_settle();
    chk("pre_reset_run", pc_q, 32'h8);
    @(negedge clk); #2; rst_n = 0; #1;
    chk("async_reset_pc_q", pc_q, 32'h0);
    @(negedge clk); rst_n = 1;
    edge_then_settle(); chk("seq_1", pc_q, 32'h4);
    edge_then_settle(); chk("seq_2", pc_q, 32'h8);
    edge_then_settle(); chk("seq_3", pc_q, 32'hC);
    @(negedge clk); trap_en = 1; trap_vector = 32'h100;
    edge_then_settle(); chk("trap_to_100", pc_q, 32'h100);
    @(negedge clk); clear_ctrl(); branch_taken = 1; branch_offset = 32'hFFFFFFF0;
    edge_then_settle(); chk("branch_back", pc_q, 32'hF0);
    @(negedge clk); clear_ctrl(); stall = 1;
    #1 chk("stall_pc_next", pc_next, 32'hF0);
    edge_then_settle(); chk("stall_1", pc_q, 32'hF0);
    edge_then_settle(); chk("stall_2", pc_q, 32'hF0);
    @(negedge clk); clear_ctrl(); jalr_en = 1; jalr_base = 32'h2001; jalr_offset = 32'h2;
    #1 chk("jalr_pc_next", pc_next, 32'h2002);
    chk("jalr_misaligned", {31'b0, misaligned}, 32'h1);
    trap_en = 1; trap_vector = 32'h80;
    #1 chk("trap_mask_misaligned", {31'b0, misaligned}, 32'h0);
    edge_then_settle(); chk("trap_over_jalr", pc_q, 32'h80);
    @(negedge clk); clear_ctrl();
    branch_taken = 1; jalr_en = 1; stall = 1; trap_en = 1; trap_vector = 32'h40;
    edge_then_settle(); chk("collision_trap_wins", pc_q, 32'h40);
    // randomized run against a plain priority model
    m_pc = 32'h40;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      PC_itself     = $urandom;
      trap_en       = ($urandom_range(0, 9) == 0);
      stall         = ($urandom_range(0, 4) == 0);
      jalr_en       = ($urandom_range(0, 3) == 0);
      branch_taken  = ($urandom_range(0, 2) == 0);
      trap_vector   = $urandom;
      jalr_base     = $urandom;
      jalr_offset   = $urandom_range(0, 1) ? $urandom : 32'($signed($urandom_range(0, 4095)) - 2048);
      branch_offset = $urandom_range(0, 1) ? $urandom : 32'($signed($urandom_range(0, 8191)) - 4096);
      if (trap_en)           exp_next = trap_vector;
      else if (stall)        exp_next = m_pc;
      else if (jalr_en)      exp_next = (jalr_base + jalr_offset) & 32'hFFFFFFFE;
      else if (branch_taken) exp_next = m_pc + branch_offset;
      else                   exp_next = m_pc + 32'd4;
      #1;
      chk("rand_pc", pc, PC_itself + 32'd4);
      chk("rand_pc_next", pc_next, exp_next);
      chk("rand_misaligned", {31'b0, misaligned}, {31'b0, (exp_next % 4 != 0) && !trap_en});
      edge_then_settle();
      chk("rand_pc_q", pc_q, exp_next);
      m_pc = exp_next;
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
